// File: rtl/fifo_cmd_pkg.sv
// rtl/fifo_cmd_pkg.sv - shared command-vector constants for the driver and the attached FIFO
package fifo_cmd_pkg;

  localparam int CMD_DATA_WIDTH   = 4;
  localparam int CMD_OPCODE_WIDTH = 2;
  localparam int CMD_EXTRA_BIT    = 1;
  localparam int CMD_LINE_WIDTH   = CMD_DATA_WIDTH + CMD_OPCODE_WIDTH + CMD_EXTRA_BIT;
  localparam int CMD_NUM_ENTRIES  = 2;

  typedef logic [CMD_OPCODE_WIDTH-1:0] opcode_t;

  localparam opcode_t OP_DO_NOTHING = 2'b00;
  localparam opcode_t OP_READ       = 2'b01;
  localparam opcode_t OP_WRITE      = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_CMD = 2'd1,
    ST_RD_CMD = 2'd2,
    ST_GAP    = 2'd3
  } cmd_state_e;

  // Vector layout seen by the FIFO: {opcode, data, trailing zero field}.
  function automatic logic [CMD_LINE_WIDTH-1:0] pack_cmd(input opcode_t op,
                                                         input logic [CMD_DATA_WIDTH-1:0] data);
    return {op, data, {CMD_EXTRA_BIT{1'b0}}};
  endfunction

endpackage

// File: rtl/fifo_cmd_driver.sv
// rtl/fifo_cmd_driver.sv - command-side master for the shared command-vector FIFO
module fifo_cmd_driver
  import fifo_cmd_pkg::*;
#(
  parameter int DATA_WIDTH   = CMD_DATA_WIDTH,
  parameter int NUM_ENTRIES  = CMD_NUM_ENTRIES,
  parameter int OPCODE_WIDTH = CMD_OPCODE_WIDTH,
  parameter int EXTRA_BIT    = CMD_EXTRA_BIT,
  parameter int LINE_WIDTH   = DATA_WIDTH + OPCODE_WIDTH + EXTRA_BIT,
  parameter int COUNT_WIDTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_ready,
  input  logic                   rd_req,
  output logic                   rd_valid,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic [LINE_WIDTH-1:0]  vector_out,
  input  logic [DATA_WIDTH-1:0]  fifo_data_in,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   busy
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] WR_CMD = ST_WR_CMD;
  localparam logic [1:0] RD_CMD = ST_RD_CMD;
  localparam logic [1:0] GAP    = ST_GAP;

  localparam logic [OPCODE_WIDTH-1:0] OPC_NOP   = OPCODE_WIDTH'(OP_DO_NOTHING);
  localparam logic [OPCODE_WIDTH-1:0] OPC_READ  = OPCODE_WIDTH'(OP_READ);
  localparam logic [OPCODE_WIDTH-1:0] OPC_WRITE = OPCODE_WIDTH'(OP_WRITE);

  localparam logic [COUNT_WIDTH-1:0] FULL_CNT = COUNT_WIDTH'(NUM_ENTRIES);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

  function automatic logic [LINE_WIDTH-1:0] cmd_line(input logic [OPCODE_WIDTH-1:0] op,
                                                     input logic [DATA_WIDTH-1:0]   data);
    return {op, data, {EXTRA_BIT{1'b0}}};
  endfunction

  logic [1:0]             state_q,    state_d;
  logic [LINE_WIDTH-1:0]  vector_q,   vector_d;
  logic [DATA_WIDTH-1:0]  rd_data_q,  rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [COUNT_WIDTH-1:0] count_q,    count_d;

  logic can_read;
  logic can_write;

  assign can_read  = (count_q != '0);
  assign can_write = (count_q < FULL_CNT);

  // A pending serviceable read blocks the write port so reads always win in IDLE.
  assign wr_ready = !reset && (state_q == IDLE) && can_write && !(rd_req && can_read);

  always_comb begin
    state_d    = state_q;
    vector_d   = vector_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    count_d    = count_q;
    case (state_q)
      IDLE: begin
        if (rd_req && can_read) begin
          state_d  = RD_CMD;
          vector_d = cmd_line(OPC_READ, '0);
        end else if (wr_valid && can_write) begin
          state_d  = WR_CMD;
          vector_d = cmd_line(OPC_WRITE, wr_data);
        end
      end
      WR_CMD: begin
        count_d  = count_q + CNT_ONE;
        state_d  = GAP;
        vector_d = cmd_line(OPC_NOP, '0);
      end
      RD_CMD: begin
        // The FIFO only drives its output while READ is on the vector.
        rd_data_d  = fifo_data_in;
        rd_valid_d = 1'b1;
        count_d    = count_q - CNT_ONE;
        state_d    = GAP;
        vector_d   = cmd_line(OPC_NOP, '0);
      end
      GAP: begin
        rd_valid_d = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d  = IDLE;
        vector_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      vector_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      vector_q   <= vector_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      count_q    <= count_d;
    end
  end

  assign vector_out = vector_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign count      = count_q;
  assign busy       = (state_q != IDLE);

  a_no_write_when_full: assert property (@(posedge clk) disable iff (reset)
    (state_q == WR_CMD) |-> (count_q < FULL_CNT));
  a_no_read_when_empty: assert property (@(posedge clk) disable iff (reset)
    (state_q == RD_CMD) |-> (count_q != '0));
  a_count_in_range: assert property (@(posedge clk) disable iff (reset)
    count_q <= FULL_CNT);

endmodule
